// File: rtl/perceptron_pkg.sv
// perceptron_pkg: shared types and constants for the perceptron trainer.
//   state_t              : trainer sequencing states (IDLE, ACCUM, DECIDE, UPDATE)
//   DEF_N_IN / DEF_WEIGHT_W / DEF_ACC_W : default widths
//   weight_max/weight_min: saturation bounds of a two's complement weight
//   WEIGHT_MAX/WEIGHT_MIN: bounds for the default weight width
package perceptron_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, DECIDE, UPDATE} state_t;

  localparam int DEF_N_IN     = 8;
  localparam int DEF_WEIGHT_W = 8;
  localparam int DEF_ACC_W    = 12;

  function automatic int weight_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int weight_min(input int w);
    return -(1 << (w - 1));
  endfunction

  localparam int WEIGHT_MAX = weight_max(DEF_WEIGHT_W);
  localparam int WEIGHT_MIN = weight_min(DEF_WEIGHT_W);

endpackage

// File: rtl/perceptron_trainer_if.sv
// perceptron_trainer_if: sample handshake and result signals of the trainer.
//   sample_valid/sample_ready : sample offer / accept handshake
//   sample_in, sample_label, threshold : sample payload, captured at handshake
//   result_valid, predict, mistake     : per-sample decision outputs
//   master : sample source, slave : trainer
interface perceptron_trainer_if import perceptron_pkg::*; #(
  parameter int N_IN  = DEF_N_IN,
  parameter int ACC_W = DEF_ACC_W
);
  logic                    sample_valid;
  logic                    sample_ready;
  logic [N_IN-1:0]         sample_in;
  logic                    sample_label;
  logic signed [ACC_W-1:0] threshold;
  logic                    result_valid;
  logic                    predict;
  logic                    mistake;

  modport master (
    output sample_valid, sample_in, sample_label, threshold,
    input  sample_ready, result_valid, predict, mistake
  );

  modport slave (
    input  sample_valid, sample_in, sample_label, threshold,
    output sample_ready, result_valid, predict, mistake
  );
endinterface

// File: rtl/perceptron_sat_add.sv
// perceptron_sat_add: combinational signed saturating add of a weight and a +/-LR step.
//   a  : signed WEIGHT_W operand
//   up : 1 adds LR, 0 subtracts LR
//   y  : result clamped to [weight_min, weight_max]
// LR is assumed smaller than 2**WEIGHT_W (two guard bits hold the raw sum).
module perceptron_sat_add import perceptron_pkg::*; #(
  parameter int          WEIGHT_W = DEF_WEIGHT_W,
  parameter int unsigned LR       = 1
) (
  input  logic signed [WEIGHT_W-1:0] a,
  input  logic                       up,
  output logic signed [WEIGHT_W-1:0] y
);
  localparam int SW = WEIGHT_W + 2;
  localparam logic signed [SW-1:0] HI   = SW'(weight_max(WEIGHT_W));
  localparam logic signed [SW-1:0] LO   = SW'(weight_min(WEIGHT_W));
  localparam logic signed [SW-1:0] STEP = SW'(LR);

  logic signed [SW-1:0] a_ext;
  logic signed [SW-1:0] sum;

  always_comb begin
    a_ext = {{2{a[WEIGHT_W-1]}}, a};
    sum   = up ? (a_ext + STEP) : (a_ext - STEP);
    if (sum > HI)      y = HI[WEIGHT_W-1:0];
    else if (sum < LO) y = LO[WEIGHT_W-1:0];
    else               y = sum[WEIGHT_W-1:0];
  end
endmodule

// File: rtl/perceptron_trainer.sv
// perceptron_trainer: owns the signed weight vector and applies the perceptron
// learning rule, one input bit per cycle.
//   clk, reset   : clock, asynchronous active-high reset
//   sif (slave)  : sample handshake in, predict/mistake/result_valid out
//   clear_errors : synchronous clear of err_count
//   weights_out  : weight i at [i*WEIGHT_W +: WEIGHT_W], live registers
//   err_count    : saturating mistake counter
// Optional macro PERCEPTRON_BIAS_EN adds a trained bias register and bias_out.
module perceptron_trainer import perceptron_pkg::*; #(
  parameter int          N_IN     = DEF_N_IN,
  parameter int          WEIGHT_W = DEF_WEIGHT_W,
  parameter int          ACC_W    = DEF_ACC_W,
  parameter int unsigned LR       = 1,
  parameter int          ERR_W    = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  perceptron_trainer_if.slave        sif,
  input  logic                       clear_errors,
  output logic [N_IN*WEIGHT_W-1:0]   weights_out,
  output logic [ERR_W-1:0]           err_count
`ifdef PERCEPTRON_BIAS_EN
  ,
  output logic signed [WEIGHT_W-1:0] bias_out
`endif
);
  localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] LAST_ACC = CNT_W'(N_IN - 1);
`ifdef PERCEPTRON_BIAS_EN
  // Bias takes one extra UPDATE slot after the last weight.
  localparam logic [CNT_W-1:0] LAST_UPD = CNT_W'(N_IN);
`else
  localparam logic [CNT_W-1:0] LAST_UPD = CNT_W'(N_IN - 1);
`endif

  state_t                     state;
  logic [CNT_W-1:0]           idx;
  logic [N_IN-1:0]            s_in;
  logic                       s_label;
  logic signed [ACC_W-1:0]    s_thr;
  logic signed [ACC_W-1:0]    acc;
  logic signed [WEIGHT_W-1:0] w [N_IN];

  logic [IDX_W-1:0]           wi;
  logic signed [ACC_W-1:0]    w_ext;
  logic signed [WEIGHT_W-1:0] upd_a;
  logic signed [WEIGHT_W-1:0] upd_y;
  logic                       upd_bias;
  logic                       predict_d;
  logic                       count_now;

  assign wi    = idx[IDX_W-1:0];
  assign w_ext = {{(ACC_W-WEIGHT_W){w[wi][WEIGHT_W-1]}}, w[wi]};

`ifdef PERCEPTRON_BIAS_EN
  logic signed [WEIGHT_W-1:0] bias;
  logic signed [ACC_W:0]      net;
  logic signed [ACC_W:0]      thr_ext;

  assign upd_bias  = (idx == CNT_W'(N_IN));
  assign net       = {acc[ACC_W-1], acc} + {{(ACC_W+1-WEIGHT_W){bias[WEIGHT_W-1]}}, bias};
  assign thr_ext   = {s_thr[ACC_W-1], s_thr};
  assign predict_d = (net >= thr_ext);
  assign upd_a     = upd_bias ? bias : w[wi];
  assign bias_out  = bias;
`else
  assign upd_bias  = 1'b0;
  assign predict_d = (acc >= s_thr);
  assign upd_a     = w[wi];
`endif

  assign count_now = (state == DECIDE) && (predict_d ^ s_label);

  // One adder serves both weight and bias updates.
  perceptron_sat_add #(.WEIGHT_W(WEIGHT_W), .LR(LR)) u_sat (
    .a  (upd_a),
    .up (s_label),
    .y  (upd_y)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      idx              <= '0;
      acc              <= '0;
      s_in             <= '0;
      s_label          <= 1'b0;
      s_thr            <= '0;
      w                <= '{default: '0};
`ifdef PERCEPTRON_BIAS_EN
      bias             <= '0;
`endif
      sif.sample_ready <= 1'b1;
      sif.result_valid <= 1'b0;
      sif.predict      <= 1'b0;
      sif.mistake      <= 1'b0;
    end else begin
      sif.result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (sif.sample_valid && sif.sample_ready) begin
            s_in             <= sif.sample_in;
            s_label          <= sif.sample_label;
            s_thr            <= sif.threshold;
            acc              <= '0;
            idx              <= '0;
            sif.sample_ready <= 1'b0;
            state            <= ACCUM;
          end
        end
        ACCUM: begin
          if (s_in[wi]) acc <= acc + w_ext;
          if (idx == LAST_ACC) begin
            idx   <= '0;
            state <= DECIDE;
          end else begin
            idx <= idx + CNT_W'(1);
          end
        end
        DECIDE: begin
          sif.predict      <= predict_d;
          sif.mistake      <= predict_d ^ s_label;
          sif.result_valid <= 1'b1;
          idx              <= '0;
          if (predict_d ^ s_label) begin
            state <= UPDATE;
          end else begin
            sif.sample_ready <= 1'b1;
            state            <= IDLE;
          end
        end
        UPDATE: begin
`ifdef PERCEPTRON_BIAS_EN
          if (upd_bias) bias <= upd_y;
          else if (s_in[wi]) w[wi] <= upd_y;
`else
          if (!upd_bias && s_in[wi]) w[wi] <= upd_y;
`endif
          if (idx == LAST_UPD) begin
            sif.sample_ready <= 1'b1;
            state            <= IDLE;
          end else begin
            idx <= idx + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A mistake landing with clear_errors counts into the freshly cleared value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count <= '0;
    end else if (clear_errors) begin
      err_count <= count_now ? ERR_W'(1) : '0;
    end else if (count_now && (err_count != '1)) begin
      err_count <= err_count + ERR_W'(1);
    end
  end

  always_comb begin
    weights_out = '0;
    for (int unsigned i = 0; i < N_IN; i++) weights_out[i*WEIGHT_W +: WEIGHT_W] = w[i];
  end
endmodule

// File: tb/tb_perceptron_trainer.sv
// tb_perceptron_trainer: directed self-checking bench for perceptron_trainer.
// A second instance with a 2-bit error counter shares the stimulus so that
// counter saturation is reachable in a short run.
module tb_perceptron_trainer;
  import perceptron_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clear_errors = 1'b0;
  logic [63:0] weights_out, weights_out2;
  logic [15:0] err_count;
  logic [1:0]  err_count2;
`ifdef PERCEPTRON_BIAS_EN
  logic [7:0]  bias_out, bias_out2;
`endif

  int total = 0;
  int bad = 0;
  int lat, tot, epochs, correct, pulses, lows;
  logic p, m;
  logic [1:0] pat;

  perceptron_trainer_if #(.N_IN(8), .ACC_W(12)) sif ();
  perceptron_trainer_if #(.N_IN(8), .ACC_W(12)) sif2 ();

  assign sif2.sample_valid = sif.sample_valid;
  assign sif2.sample_in    = sif.sample_in;
  assign sif2.sample_label = sif.sample_label;
  assign sif2.threshold    = sif.threshold;

  always #5 clk = ~clk;

  perceptron_trainer #(.N_IN(8), .WEIGHT_W(8), .ACC_W(12), .LR(1), .ERR_W(16)) dut (
    .clk(clk), .reset(reset), .sif(sif), .clear_errors(clear_errors),
    .weights_out(weights_out), .err_count(err_count)
`ifdef PERCEPTRON_BIAS_EN
    , .bias_out(bias_out)
`endif
  );

  perceptron_trainer #(.N_IN(8), .WEIGHT_W(8), .ACC_W(12), .LR(1), .ERR_W(2)) dut_sat (
    .clk(clk), .reset(reset), .sif(sif2), .clear_errors(clear_errors),
    .weights_out(weights_out2), .err_count(err_count2)
`ifdef PERCEPTRON_BIAS_EN
    , .bias_out(bias_out2)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; returns at handshake edge +1 with sample_valid dropped.
  task automatic start_sample(input logic [7:0] din, input logic lbl, input logic [11:0] thr);
    int n = 0;
    while (!sif.sample_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (n >= 100) check("ready_timeout", 64'(sif.sample_ready), 64'd1);
    sif.sample_valid = 1'b1;
    sif.sample_in    = din;
    sif.sample_label = lbl;
    sif.threshold    = thr;
    @(posedge clk); #1;
    sif.sample_valid = 1'b0;
  endtask

  // lat: edges from handshake to result_valid; tot: edge at which the next sample can be taken.
  task automatic finish_sample();
    lat = 0;
    while (!sif.result_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    if (lat >= 40) check("rv_timeout", 64'(sif.result_valid), 64'd1);
    p = sif.predict;
    m = sif.mistake;
    tot = lat;
    while (!sif.sample_ready && tot < 60) begin @(posedge clk); #1; tot++; end
    if (tot >= 60) check("done_timeout", 64'(sif.sample_ready), 64'd1);
    tot++;
  endtask

  task automatic run_sample(input logic [7:0] din, input logic lbl, input logic [11:0] thr);
    start_sample(din, lbl, thr);
    finish_sample();
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sif.sample_valid = 1'b0;
    sif.sample_in    = '0;
    sif.sample_label = 1'b0;
    sif.threshold    = '0;

    // Reset values, observed before any clock edge
    #1 reset = 1'b1;
    #1;
    check("rst_ready", 64'(sif.sample_ready), 64'd1);
    check("rst_rv",    64'(sif.result_valid), 64'd0);
    check("rst_pred",  64'(sif.predict), 64'd0);
    check("rst_mis",   64'(sif.mistake), 64'd0);
    check("rst_err",   64'(err_count), 64'd0);
    check("rst_w",     weights_out, 64'd0);
    #6 reset = 1'b0;
    @(posedge clk); #1;

    // All-zero input, threshold 0: acc=0>=0 predicts 1, label 0 -> mistake
    run_sample(8'h00, 1'b0, 12'h000);
    check("z_pred", 64'(p), 64'd1);
    check("z_mis",  64'(m), 64'd1);
    check("z_lat",  64'(lat), 64'd9);
    check("z_tot",  64'(tot), 64'd18);
    check("z_w",    weights_out, 64'd0);
    check("z_err",  64'(err_count), 64'd1);
    check("z_err2", 64'(err_count2), 64'd1);

    // All-ones input, label 1, threshold 1: first sample mistakes, weights -> +1
    do_reset();
    check("r2_err", 64'(err_count), 64'd0);
    run_sample(8'hFF, 1'b1, 12'h001);
    check("ff1_pred", 64'(p), 64'd0);
    check("ff1_mis",  64'(m), 64'd1);
    check("ff1_tot",  64'(tot), 64'd18);
    check("ff1_w",    weights_out, 64'h0101010101010101);
    check("ff1_err",  64'(err_count), 64'd1);
    // Repeat: acc=8>=1, correct, no update
    run_sample(8'hFF, 1'b1, 12'h001);
    check("ff2_pred", 64'(p), 64'd1);
    check("ff2_mis",  64'(m), 64'd0);
    check("ff2_lat",  64'(lat), 64'd9);
    check("ff2_tot",  64'(tot), 64'd10);
    check("ff2_w",    weights_out, 64'h0101010101010101);
    check("ff2_err",  64'(err_count), 64'd1);

    // Positive saturation: w0 climbs to +127 and stops
    do_reset();
    for (int k = 0; k < 130; k++) run_sample(8'h01, 1'b1, 12'h7FF);
    check("satp_mis",  64'(m), 64'd1);
    check("satp_w",    weights_out, 64'h000000000000007F);
    check("satp_err",  64'(err_count), 64'd130);
    check("satp_err2", 64'(err_count2), 64'd3);
    check("satp_w2",   weights_out2, 64'h000000000000007F);
    // Negative saturation: 260 decrements from +127 stop at -128
    for (int k = 0; k < 260; k++) run_sample(8'h01, 1'b0, 12'h800);
    check("satn_pred", 64'(p), 64'd1);
    check("satn_w",    weights_out, 64'h0000000000000080);
    check("satn_err",  64'(err_count), 64'd390);
    check("satn_err2", 64'(err_count2), 64'd3);
    check("satn_w2",   weights_out2, 64'h0000000000000080);
    check("satn_rdy2", 64'(sif2.sample_ready), 64'd1);
    check("satn_pr2",  64'(sif2.predict), 64'd1);
    check("satn_mi2",  64'(sif2.mistake), 64'd1);
    check("satn_rv2",  64'(sif2.result_valid), 64'd0);

    // AND gate, threshold 2: epoch 1 errs once on 11, epoch 2 is clean
    do_reset();
    epochs = 0;
    correct = 0;
    do begin
      epochs++;
      clear_errors = 1'b1;
      @(posedge clk); #1;
      clear_errors = 1'b0;
      correct = 0;
      for (int j = 0; j < 4; j++) begin
        pat = 2'(j);
        run_sample({6'b0, pat}, pat[1] & pat[0], 12'd2);
        if (p === (pat[1] & pat[0])) correct++;
      end
    end while (err_count != 16'd0 && epochs < 10);
    check("and_epochs",  64'(epochs), 64'd2);
    check("and_correct", 64'(correct), 64'd4);
    check("and_err",     64'(err_count), 64'd0);
    check("and_w",       weights_out, 64'h0000000000000101);

    // clear_errors coinciding with a counting mistake leaves 1
    run_sample(8'h00, 1'b0, 12'h000);
    check("clr_pre", 64'(err_count), 64'd1);
    start_sample(8'h00, 1'b0, 12'h000);
    repeat (8) @(posedge clk);
    #1 clear_errors = 1'b1;
    @(posedge clk); #1;
    clear_errors = 1'b0;
    check("clr_rv",  64'(sif.result_valid), 64'd1);
    check("clr_mis", 64'(err_count), 64'd1);
    finish_sample();
    clear_errors = 1'b1;
    @(posedge clk); #1;
    clear_errors = 1'b0;
    check("clr_only", 64'(err_count), 64'd0);

    // sample_valid held through ACCUM/UPDATE; payload changes after handshake are ignored
    sif.sample_valid = 1'b1;
    sif.sample_in    = 8'h04;
    sif.sample_label = 1'b1;
    sif.threshold    = 12'd100;
    @(posedge clk); #1;
    sif.sample_in = 8'h08;
    pulses = 0;
    lows = 0;
    for (int c = 1; c <= 17; c++) begin
      @(posedge clk); #1;
      if (sif.result_valid) pulses++;
      if (!sif.sample_ready) lows++;
    end
    check("hold_pulses", 64'(pulses), 64'd1);
    check("hold_lows",   64'(lows), 64'd16);
    check("hold_ready",  64'(sif.sample_ready), 64'd1);
    check("hold_w",      weights_out, 64'h0000000000010101);
    check("hold_err",    64'(err_count), 64'd1);
    @(posedge clk); #1;
    sif.sample_valid = 1'b0;
    finish_sample();
    check("hold2_pred", 64'(p), 64'd0);
    check("hold2_mis",  64'(m), 64'd1);
    check("hold2_w",    weights_out, 64'h0000000001010101);
    check("hold2_err",  64'(err_count), 64'd2);

    // Reset after UPDATE index 3: partial update visible, then cleared asynchronously
    do_reset();
    start_sample(8'hFF, 1'b1, 12'h001);
    repeat (13) @(posedge clk);
    #1;
    check("mid_w",   weights_out, 64'h0000000001010101);
    check("mid_mis", 64'(sif.mistake), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_ready", 64'(sif.sample_ready), 64'd1);
    check("mid_rst_rv",    64'(sif.result_valid), 64'd0);
    check("mid_rst_pred",  64'(sif.predict), 64'd0);
    check("mid_rst_mis",   64'(sif.mistake), 64'd0);
    check("mid_rst_err",   64'(err_count), 64'd0);
    check("mid_rst_w",     weights_out, 64'd0);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    run_sample(8'hFF, 1'b1, 12'h001);
    check("post_pred", 64'(p), 64'd0);
    check("post_mis",  64'(m), 64'd1);
    check("post_lat",  64'(lat), 64'd9);
    check("post_tot",  64'(tot), 64'd18);
    check("post_w",    weights_out, 64'h0101010101010101);
    check("post_err",  64'(err_count), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
